// File: rtl/alu_mul_seq_pkg.sv
// ALU operation codes and the multiplier controller's state encoding,
// shared by the controller and whatever hosts the core ALU beside it.
package rv32i_alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result handshake plus the borrowed-ALU operand/result path of the
// sequential multiplier; master = requester and ALU host, slave = controller.
interface alu_mul_seq_if #(
   parameter int XLEN = 32
);
   logic                start;
   logic [XLEN-1:0]     multiplicand;
   logic [XLEN-1:0]     multiplier;
   logic                ready;
   logic                busy;
   logic                done;
   logic [2*XLEN-1:0]   product;
   logic [3:0]          alu_op;
   logic [XLEN-1:0]     alu_data1;
   logic [XLEN-1:0]     alu_data2;
   logic [XLEN-1:0]     alu_result;

   modport master (
      output start, multiplicand, multiplier, alu_result,
      input  ready, busy, done, product, alu_op, alu_data1, alu_data2
   );

   modport slave (
      input  start, multiplicand, multiplier, alu_result,
      output ready, busy, done, product, alu_op, alu_data1, alu_data2
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier using the core ALU for one ADD per cycle; done pulses
// XLEN+1 cycles after an accepted start. start is only taken when ready (IDLE or DONE).
module alu_mul_seq
   import rv32i_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_mul_seq_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   logic [1:0]          r_state;
   logic [XLEN-1:0]     r_acc_hi;
   logic [XLEN-1:0]     r_acc_lo;
   logic [XLEN-1:0]     r_mcand;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*XLEN-1:0]   r_product;

   logic                w_ready;
   logic                w_busy;
   logic                w_accept;
   logic                w_last;
   logic                w_carry;
   logic [XLEN-1:0]     w_addend;
   logic [2*XLEN-1:0]   w_next_acc;

   assign w_ready  = (r_state == IDLE) || (r_state == DONE);
   assign w_busy   = (r_state == BUSY);
   assign w_accept = bus.start && w_ready;
   assign w_last   = (r_cnt == CNT_W'(XLEN - 1));
   assign w_addend = r_acc_lo[0] ? r_mcand : '0;

   // The ALU has no carry-out: a wrapped sum is smaller than the value added to.
   assign w_carry    = r_acc_lo[0] & (bus.alu_result < r_acc_hi);
   assign w_next_acc = {w_carry, bus.alu_result, r_acc_lo[XLEN-1:1]};

   assign bus.ready     = w_ready;
   assign bus.busy      = w_busy;
   assign bus.done      = (r_state == DONE);
   assign bus.product   = r_product;
   assign bus.alu_op    = ALU_ADD;
   assign bus.alu_data1 = w_busy ? r_acc_hi : '0;
   assign bus.alu_data2 = w_busy ? w_addend : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_acc_hi  <= '0;
         r_acc_lo  <= '0;
         r_mcand   <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_mcand  <= bus.multiplicand;
                  r_acc_lo <= bus.multiplier;
                  r_acc_hi <= '0;
                  r_cnt    <= '0;
                  r_state  <= BUSY;
               end else begin
                  r_state  <= IDLE;
               end
            end
            BUSY: begin
               {r_acc_hi, r_acc_lo} <= w_next_acc;
               r_cnt                <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_product <= w_next_acc;
                  r_state   <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural core ALU, operand-level scoreboard,
// per-iteration accumulator model, table of products and handshake corner cases.
module tb_alu_mul_seq;
   import rv32i_alu_pkg::*;

   logic clk;
   logic rst_n;

   alu_mul_seq_if #(.XLEN(32)) bus ();

   alu_mul_seq #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus.alu_result = '0;
      case (bus.alu_op)
         ALU_ADD: bus.alu_result = bus.alu_data1 + bus.alu_data2;
         ALU_SUB: bus.alu_result = bus.alu_data1 - bus.alu_data2;
         ALU_AND: bus.alu_result = bus.alu_data1 & bus.alu_data2;
         ALU_OR:  bus.alu_result = bus.alu_data1 | bus.alu_data2;
         default: bus.alu_result = '0;
      endcase
   end

   int n_chk  = 0;
   int n_fail = 0;
   int done_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard and independent accumulator model, sampled on the falling edge.
   logic [63:0] sb[$];
   logic        p_acc  = 1'b0;
   logic        p_busy = 1'b0;
   logic [31:0] p_a, p_b;
   logic [31:0] m_hi, m_lo, m_mc;
   logic [32:0] m_sum;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         p_acc  = 1'b0;
         p_busy = 1'b0;
      end else begin
         if (p_acc) begin
            m_hi = '0;
            m_lo = p_b;
            m_mc = p_a;
         end else if (p_busy) begin
            m_sum = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_mc} : 33'd0);
            m_lo  = {m_sum[0], m_lo[31:1]};
            m_hi  = m_sum[32:1];
         end
         if (bus.busy) begin
            chk("alu_op_add", 64'(bus.alu_op), 64'(ALU_ADD));
            chk("alu_data1_acc_hi", 64'(bus.alu_data1), 64'(m_hi));
            chk("alu_data2_addend", 64'(bus.alu_data2), 64'(m_lo[0] ? m_mc : 32'd0));
         end
         if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) chk("sb_unexpected_done", 64'd1, 64'd0);
            else chk("sb_product", bus.product, sb.pop_front());
         end
         p_acc = bus.start && bus.ready;
         if (p_acc) begin
            p_a = bus.multiplicand;
            p_b = bus.multiplier;
            sb.push_back(64'(p_a) * 64'(p_b));
         end
         p_busy = bus.busy;
      end
   end

   task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(posedge clk); #1;
      bus.start        = 1'b0;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
   endtask

   // Called right after drive_start: waits for done, checks latency and result.
   task automatic wait_done(input logic [63:0] exp, input string nm);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk({nm, "_ready_low"}, 64'(bus.ready), 64'd0);
            chk({nm, "_busy_high"}, 64'(bus.busy), 64'd1);
         end
      end while (!bus.done && lat < 40);
      chk({nm, "_latency"}, 64'(lat), 64'd33);
      chk({nm, "_product"}, bus.product, exp);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, 64'(bus.done), 64'd0);
      chk({nm, "_ready_after"}, 64'(bus.ready), 64'd1);
      chk({nm, "_product_held"}, bus.product, exp);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[7];
   int   d0;

   initial begin
      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
      vecs[3] = '{32'd0,          32'h1234,       64'h0};
      vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
      vecs[5] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
      vecs[6] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(bus.ready), 64'd1);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_product", bus.product, 64'd0);
      chk("rst_data1", 64'(bus.alu_data1), 64'd0);
      chk("rst_data2", 64'(bus.alu_data2), 64'd0);
      chk("rst_alu_op", 64'(bus.alu_op), 64'(ALU_ADD));
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         drive_start(vecs[i].a, vecs[i].b);
         wait_done(vecs[i].exp, $sformatf("vec%0d", i));
      end

      // start while busy is ignored
      d0 = done_cnt;
      drive_start(32'd3, 32'd5);
      repeat (8) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (40) @(negedge clk);
      chk("ignored_product", bus.product, 64'd15);
      chk("ignored_one_done", 64'(done_cnt - d0), 64'd1);

      // start held during the DONE cycle: back-to-back run
      drive_start(32'd3, 32'd5);
      repeat (32) @(negedge clk);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.multiplicand = 32'd6; bus.multiplier = 32'd7;
      @(negedge clk);
      chk("b2b_first_done", 64'(bus.done), 64'd1);
      chk("b2b_first_product", bus.product, 64'd15);
      chk("b2b_accepting", 64'(bus.ready), 64'd1);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.multiplicand = $urandom; bus.multiplier = $urandom;
      wait_done(64'd42, "b2b_second");

      // asynchronous reset mid-run
      d0 = done_cnt;
      drive_start(32'd3, 32'd5);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_ready", 64'(bus.ready), 64'd1);
      chk("arst_product", bus.product, 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_data1", 64'(bus.alu_data1), 64'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
      drive_start(32'd2, 32'd2);
      wait_done(64'd4, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
